// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry skid buffer (main + skid).
// Optional CSR zimm decode enabled by defining IMM_GEN_CSR_EN.
module imm_gen_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
);

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_CSR   = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    fmt_e            fmt;
    logic            illegal;
  } ent_t;

  ent_t main_q, main_d, skid_q, skid_d, dec;
  logic main_v_q, main_v_d, skid_v_q, skid_v_d, rdy_q, rdy_d;
  logic accept, drain;
  logic [4:0] opc;
  logic [2:0] f3;
  logic [5:0] shamt;

  assign opc = in_inst[6:2];
  assign f3  = in_inst[14:12];

  always_comb begin
    dec   = '0;
    dec.fmt = FMT_NONE;
    shamt = (XLEN == 32) ? {1'b0, in_inst[24:20]} : in_inst[25:20];
    if (in_inst[1:0] != 2'b11) begin
      dec.illegal = 1'b1;
    end else begin
      unique case (opc)
        5'b00000, 5'b11001: begin
          dec.fmt = FMT_I;
          dec.imm = XLEN'($signed(in_inst[31:20]));
        end
        5'b00100: begin
          if (f3 == 3'b001 || f3 == 3'b101) begin
            if (XLEN == 32 && in_inst[25]) begin
              dec.illegal = 1'b1;
            end else begin
              dec.fmt = FMT_SHAMT;
              dec.imm = XLEN'(shamt);
            end
          end else begin
            dec.fmt = FMT_I;
            dec.imm = XLEN'($signed(in_inst[31:20]));
          end
        end
        5'b01000: begin
          dec.fmt = FMT_S;
          dec.imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
        end
        5'b11000: begin
          dec.fmt = FMT_B;
          dec.imm = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                   in_inst[11:8], 1'b0}));
        end
        5'b01101, 5'b00101: begin
          dec.fmt = FMT_U;
          dec.imm = XLEN'($signed({in_inst[31:12], 12'b0}));
        end
        5'b11011: begin
          dec.fmt = FMT_J;
          dec.imm = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                   in_inst[30:21], 1'b0}));
        end
        5'b01100, 5'b01110, 5'b00011, 5'b00110: begin
          dec.fmt = FMT_NONE;
        end
        5'b11100: begin
`ifdef IMM_GEN_CSR_EN
          if (f3 == 3'b101 || f3 == 3'b110 || f3 == 3'b111) begin
            dec.fmt = FMT_CSR;
            dec.imm = XLEN'(in_inst[19:15]);
          end
`else
          dec.fmt = FMT_NONE;
`endif
        end
        default: dec.illegal = 1'b1;
      endcase
    end
    dec.target = in_pc + dec.imm;
  end

  assign accept = in_valid && rdy_q;
  assign drain  = main_v_q && out_ready;

  // Skid can only fill while main stalls, so a draining full skid never
  // coincides with an accept (rdy_q is low whenever skid holds data).
  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (drain && skid_v_q) begin
      main_d   = skid_q;
      skid_v_d = 1'b0;
    end else if (drain || !main_v_q) begin
      main_v_d = accept;
      if (accept) main_d = dec;
    end else if (accept) begin
      skid_v_d = 1'b1;
      skid_d   = dec;
    end
    rdy_d = !skid_v_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      rdy_q    <= rdy_d;
    end
  end

  assign in_ready    = rdy_q;
  assign out_valid   = main_v_q;
  assign out_imm     = main_q.imm;
  assign out_fmt     = main_q.fmt;
  assign out_target  = main_q.target;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench driving an XLEN=32 and an XLEN=64 instance with shared stimulus.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] inst = '0;
  logic [63:0] pc = '0;

  logic        rdy32, vld32, ill32;
  logic [31:0] imm32, tgt32;
  logic [2:0]  fmt32;
  logic        rdy64, vld64, ill64;
  logic [63:0] imm64, tgt64;
  logic [2:0]  fmt64;

  int unsigned checks = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32)) u32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_inst(inst), .in_pc(pc[31:0]), .out_valid(vld32), .out_ready(out_ready),
    .out_imm(imm32), .out_fmt(fmt32), .out_target(tgt32), .out_illegal(ill32)
  );

  imm_gen_pipe #(.XLEN(64)) u64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_inst(inst), .in_pc(pc), .out_valid(vld64), .out_ready(out_ready),
    .out_imm(imm64), .out_fmt(fmt64), .out_target(tgt64), .out_illegal(ill64)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single cycle with out_ready high.
  task automatic send(input logic [31:0] i, input logic [63:0] p);
    inst = i;
    pc = p;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_valid", {63'd0, vld32}, 64'd0);
    check("rst_ready", {63'd0, rdy32}, 64'd1);
    check("rst_imm", {32'd0, imm32}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // addi x1,x0,-1
    send(32'hFFF00093, 64'h0);
    check("addi_valid", {63'd0, vld32}, 64'd1);
    check("addi_imm", {32'd0, imm32}, 64'hFFFF_FFFF);
    check("addi_fmt", {61'd0, fmt32}, 64'd1);
    check("addi_tgt", {32'd0, tgt32}, 64'hFFFF_FFFF);
    check("addi_tgt64", tgt64, 64'hFFFF_FFFF_FFFF_FFFF);

    // beq, back-to-back with the previous result draining
    send(32'hFE000EE3, 64'h100);
    check("beq_imm", {32'd0, imm32}, 64'hFFFF_FFFC);
    check("beq_fmt", {61'd0, fmt32}, 64'd3);
    check("beq_tgt", {32'd0, tgt32}, 64'h0000_00FC);

    send(32'h001000EF, 64'h200);
    check("jal_imm", {32'd0, imm32}, 64'h800);
    check("jal_fmt", {61'd0, fmt32}, 64'd5);
    check("jal_tgt", {32'd0, tgt32}, 64'hA00);

    // sw x2,-8(x1)
    send(32'hFE20AC23, 64'h1000);
    check("sw_imm", {32'd0, imm32}, 64'hFFFF_FFF8);
    check("sw_fmt", {61'd0, fmt32}, 64'd2);
    check("sw_tgt", {32'd0, tgt32}, 64'hFF8);

    // lui x1,0x80000 sign-extends on RV64
    send(32'h800000B7, 64'h0);
    check("lui_imm32", {32'd0, imm32}, 64'h8000_0000);
    check("lui_fmt", {61'd0, fmt32}, 64'd4);
    check("lui_imm64", imm64, 64'hFFFF_FFFF_8000_0000);

    // slli x1,x1,33: illegal on RV32, shamt 33 on RV64
    send(32'h02109093, 64'h0);
    check("slli33_ill32", {63'd0, ill32}, 64'd1);
    check("slli33_imm32", {32'd0, imm32}, 64'd0);
    check("slli33_fmt32", {61'd0, fmt32}, 64'd0);
    check("slli33_fmt64", {61'd0, fmt64}, 64'd6);
    check("slli33_imm64", imm64, 64'd33);
    check("slli33_ill64", {63'd0, ill64}, 64'd0);

    send(32'h00309093, 64'h0);
    check("slli3_fmt32", {61'd0, fmt32}, 64'd6);
    check("slli3_imm32", {32'd0, imm32}, 64'd3);

    send(32'h0000007F, 64'h40);
    check("op7f_ill", {63'd0, ill32}, 64'd1);
    check("op7f_imm", {32'd0, imm32}, 64'd0);
    check("op7f_tgt", {32'd0, tgt32}, 64'h40);

    send(32'h00000010, 64'h0);
    check("low2_ill", {63'd0, ill32}, 64'd1);

    // add x1,x2,x3: legal, no immediate
    send(32'h003100B3, 64'h0);
    check("add_fmt", {61'd0, fmt32}, 64'd0);
    check("add_ill", {63'd0, ill32}, 64'd0);

    // csrrwi
    send(32'h51E2D073, 64'h0);
`ifdef IMM_GEN_CSR_EN
    check("csr_fmt", {61'd0, fmt32}, 64'd7);
    check("csr_imm", {32'd0, imm32}, 64'd5);
`else
    check("csr_fmt", {61'd0, fmt32}, 64'd0);
    check("csr_imm", {32'd0, imm32}, 64'd0);
`endif
    check("csr_ill", {63'd0, ill32}, 64'd0);

    tick();
    check("idle_valid", {63'd0, vld32}, 64'd0);

    // Backpressure: A in main, B in skid, C held off
    out_ready = 1'b0;
    in_valid = 1'b1;
    inst = 32'h00100093; pc = 64'h10;
    tick();
    check("bp_a_valid", {63'd0, vld32}, 64'd1);
    check("bp_a_rdy", {63'd0, rdy32}, 64'd1);
    inst = 32'h00200093; pc = 64'h20;
    tick();
    check("bp_b_rdy", {63'd0, rdy32}, 64'd0);
    check("bp_b_imm", {32'd0, imm32}, 64'd1);
    inst = 32'h00300093; pc = 64'h30;
    tick();
    tick();
    check("bp_hold_rdy", {63'd0, rdy32}, 64'd0);
    check("bp_hold_imm", {32'd0, imm32}, 64'd1);
    check("bp_hold_tgt", {32'd0, tgt32}, 64'h11);
    out_ready = 1'b1;
    tick();
    check("bp_out_b", {32'd0, imm32}, 64'd2);
    check("bp_out_b_tgt", {32'd0, tgt32}, 64'h22);
    check("bp_out_b_rdy", {63'd0, rdy32}, 64'd1);
    tick();
    in_valid = 1'b0;
    check("bp_out_c", {32'd0, imm32}, 64'd3);
    check("bp_out_c_tgt", {32'd0, tgt32}, 64'h33);
    check("bp_out_c_valid", {63'd0, vld32}, 64'd1);
    tick();
    check("bp_done_valid", {63'd0, vld32}, 64'd0);

    // Flush with two entries buffered; concurrent input discarded
    out_ready = 1'b0;
    in_valid = 1'b1;
    inst = 32'h00400093; pc = 64'h0;
    tick();
    inst = 32'h00500093;
    tick();
    flush = 1'b1;
    inst = 32'h00600093;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_valid", {63'd0, vld32}, 64'd0);
    check("fl_rdy", {63'd0, rdy32}, 64'd1);
    out_ready = 1'b1;
    tick();
    tick();
    check("fl_no_stale", {63'd0, vld32}, 64'd0);

    // Asynchronous reset mid-cycle with two entries buffered
    out_ready = 1'b0;
    in_valid = 1'b1;
    inst = 32'h00700093; pc = 64'h8;
    tick();
    inst = 32'h00800093;
    tick();
    in_valid = 1'b0;
    check("pre_rst_valid", {63'd0, vld32}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", {63'd0, vld32}, 64'd0);
    check("arst_rdy", {63'd0, rdy32}, 64'd1);
    check("arst_imm", {32'd0, imm32}, 64'd0);
    check("arst_tgt", {32'd0, tgt32}, 64'd0);
    check("arst_tgt64", tgt64, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    check("arst_no_stale", {63'd0, vld32}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
